// File: rtl/mod_addsub_lanes_pkg.sv
// Shared constants, types and modular helpers for mod_addsub_lanes.
// Optional halving stage is enabled by MOD_ADDSUB_HALVE_EN.
package mod_addsub_lanes_pkg;

  localparam int W  = 24;
  localparam int HW = 12;
  localparam int KQ = 3329;
  localparam int DQ = 8380417;

  typedef enum logic {
    KD_KYBER = 1'b0,
    KD_DIL   = 1'b1
  } kd_mode_e;

  typedef struct packed {
    logic     valid;
    kd_mode_e mode;
`ifdef MOD_ADDSUB_HALVE_EN
    logic     halve;
`endif
  } stage_t;

  // Kyber: {hi13, lo13}; Dilithium: bits [23:0], borrow in bit 23.
  typedef struct packed {
    logic [2*HW+1:0] sum;
    logic [2*HW+1:0] diff;
  } lane_raw_t;

  function automatic logic [W-1:0] fix_sum(
    input logic [W-1:0] s,
    input logic [W-1:0] q
  );
    return (s >= q) ? s - q : s;
  endfunction

  function automatic logic [W-1:0] fix_diff(
    input logic [W-1:0] d,
    input logic         bw,
    input logic [W-1:0] q
  );
    return bw ? d + q : d;
  endfunction

  function automatic logic [W-1:0] halve_mod(
    input logic [W-1:0] x,
    input logic [W-1:0] q
  );
    logic [W:0] t;
    t = x[0] ? {1'b0, x} + {1'b0, q} : {1'b0, x};
    return t[W:1];
  endfunction

endpackage

// File: rtl/mod_addsub_lane.sv
// One lane of the modular add/sub datapath: raw S1 register, corrected S2.
// Halving is present only when MOD_ADDSUB_HALVE_EN is defined.
module mod_addsub_lane
  import mod_addsub_lanes_pkg::*;
#(
  parameter int KYB_Q = KQ,
  parameter int DIL_Q = DQ
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld1,
  input  logic         ld2,
  input  kd_mode_e     mode_in,
  input  kd_mode_e     mode_s1,
`ifdef MOD_ADDSUB_HALVE_EN
  input  logic         halve_s1,
`endif
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic [W-1:0] diff
);

  localparam logic [W-1:0] QK = 24'(KYB_Q);
  localparam logic [W-1:0] QD = 24'(DIL_Q);
  localparam logic [W-1:0] MK = 24'hfff;
  localparam logic [W-1:0] MD = 24'h7fffff;

  lane_raw_t    raw_d, raw_q;
  logic [W-1:0] ks_hi, ks_lo, kd_hi, kd_lo;
  logic [W-1:0] ds, dd, sum_n, diff_n;

  always_comb begin
    raw_d = '0;
    if (mode_in == KD_DIL) begin
      raw_d.sum[23:0]  = {1'b0, a[22:0]} + {1'b0, b[22:0]};
      raw_d.diff[23:0] = {1'b0, a[22:0]} - {1'b0, b[22:0]};
    end else begin
      raw_d.sum  = {{1'b0, a[23:12]} + {1'b0, b[23:12]},
                    {1'b0, a[11:0]}  + {1'b0, b[11:0]}};
      raw_d.diff = {{1'b0, a[23:12]} - {1'b0, b[23:12]},
                    {1'b0, a[11:0]}  - {1'b0, b[11:0]}};
    end
  end

  always_comb begin
    ks_hi = fix_sum({11'd0, raw_q.sum[25:13]}, QK) & MK;
    ks_lo = fix_sum({11'd0, raw_q.sum[12:0]}, QK) & MK;
    kd_hi = fix_diff({12'd0, raw_q.diff[24:13]},
                     raw_q.diff[25], QK) & MK;
    kd_lo = fix_diff({12'd0, raw_q.diff[11:0]},
                     raw_q.diff[12], QK) & MK;
    ds    = fix_sum(raw_q.sum[23:0], QD) & MD;
    dd    = fix_diff({1'b0, raw_q.diff[22:0]},
                     raw_q.diff[23], QD) & MD;
`ifdef MOD_ADDSUB_HALVE_EN
    if (halve_s1) begin
      ks_hi = halve_mod(ks_hi, QK) & MK;
      ks_lo = halve_mod(ks_lo, QK) & MK;
      kd_hi = halve_mod(kd_hi, QK) & MK;
      kd_lo = halve_mod(kd_lo, QK) & MK;
      ds    = halve_mod(ds, QD) & MD;
      dd    = halve_mod(dd, QD) & MD;
    end
`endif
    sum_n  = {ks_hi[11:0], ks_lo[11:0]};
    diff_n = {kd_hi[11:0], kd_lo[11:0]};
    if (mode_s1 == KD_DIL) begin
      sum_n  = ds;
      diff_n = dd;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      raw_q <= '0;
      sum   <= '0;
      diff  <= '0;
    end else begin
      if (ld1) raw_q <= raw_d;
      if (ld2) begin
        sum  <= sum_n;
        diff <= diff_n;
      end
    end
  end

endmodule

// File: rtl/mod_addsub_lanes.sv
// Multi-lane modular add/sub, 2-stage valid/ready pipeline, Kyber or Dilithium.
// Define MOD_ADDSUB_HALVE_EN to add the halve input (x/2 mod q).
module mod_addsub_lanes #(
  parameter int LANES = 2,
  parameter int KQ    = 3329,
  parameter int DQ    = 8380417,
  parameter int W     = 24
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               kd_mode,
`ifdef MOD_ADDSUB_HALVE_EN
  input  logic               halve,
`endif
  input  logic [LANES*W-1:0] in_a,
  input  logic [LANES*W-1:0] in_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LANES*W-1:0] out_sum,
  output logic [LANES*W-1:0] out_diff
);
  import mod_addsub_lanes_pkg::*;

  stage_t s1;
  logic   s2_valid;
  logic   acc, adv2;

  assign adv2      = s1.valid & (~s2_valid | out_ready);
  assign in_ready  = ~s1.valid | adv2;
  assign acc       = in_valid & in_ready;
  assign out_valid = s2_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1       <= '0;
      s2_valid <= 1'b0;
    end else begin
      if (acc) begin
        s1.valid <= 1'b1;
        s1.mode  <= kd_mode_e'(kd_mode);
`ifdef MOD_ADDSUB_HALVE_EN
        s1.halve <= halve;
`endif
      end else if (adv2) begin
        s1.valid <= 1'b0;
      end
      s2_valid <= adv2 | (s2_valid & ~out_ready);
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    mod_addsub_lane #(
      .KYB_Q(KQ),
      .DIL_Q(DQ)
    ) u_lane (
      .clk     (clk),
      .rst     (rst),
      .ld1     (acc),
      .ld2     (adv2),
      .mode_in (kd_mode_e'(kd_mode)),
      .mode_s1 (s1.mode),
`ifdef MOD_ADDSUB_HALVE_EN
      .halve_s1(s1.halve),
`endif
      .a       (in_a[i*W +: W]),
      .b       (in_b[i*W +: W]),
      .sum     (out_sum[i*W +: W]),
      .diff    (out_diff[i*W +: W])
    );
  end

endmodule

// File: tb/tb_mod_addsub_lanes.sv
// Self-checking bench for mod_addsub_lanes against a modular-arithmetic model.
// Halve tests run when MOD_ADDSUB_HALVE_EN is defined.
module tb_mod_addsub_lanes;
  localparam int LANES = 2;
  localparam int W  = 24;
  localparam int N  = LANES * W;
  localparam int KQ = 3329;
  localparam int DQ = 8380417;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, kd_mode;
  logic         out_valid, out_ready, halve;
  logic [N-1:0] in_a, in_b, out_sum, out_diff;

  always #5 clk = ~clk;

  mod_addsub_lanes #(.LANES(LANES), .KQ(KQ), .DQ(DQ), .W(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .kd_mode  (kd_mode),
`ifdef MOD_ADDSUB_HALVE_EN
    .halve    (halve),
`endif
    .in_a     (in_a),
    .in_b     (in_b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .out_diff (out_diff)
  );

  typedef struct {
    logic [N-1:0] s;
    logic [N-1:0] d;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  bit   last_acc;
  int   idx;
  logic [N-1:0] snap_s, snap_d;
  logic [N-1:0] pa[4], pb[4];
  logic         pm[4];

  function automatic int hv(input int x, input int m);
    return (x % 2 != 0) ? (x + m) / 2 : x / 2;
  endfunction

  function automatic exp_t model(input logic mode, input logic [N-1:0] a,
                                 input logic [N-1:0] b, input logic h);
    exp_t r;
    int x, y, s, d;
    r.s = '0;
    r.d = '0;
    for (int l = 0; l < LANES; l++) begin
      if (mode) begin
        x = int'(a[l*W +: 23]);
        y = int'(b[l*W +: 23]);
        s = (x + y) % DQ;
        d = (x - y + DQ) % DQ;
        if (h) begin s = hv(s, DQ); d = hv(d, DQ); end
        r.s[l*W +: W] = s[23:0];
        r.d[l*W +: W] = d[23:0];
      end else begin
        for (int k = 0; k < 2; k++) begin
          x = int'(a[l*W+k*12 +: 12]);
          y = int'(b[l*W+k*12 +: 12]);
          s = (x + y) % KQ;
          d = (x - y + KQ) % KQ;
          if (h) begin s = hv(s, KQ); d = hv(d, KQ); end
          r.s[l*W+k*12 +: 12] = s[11:0];
          r.d[l*W+k*12 +: 12] = d[11:0];
        end
      end
    end
    return r;
  endfunction

  function automatic logic [N-1:0] rnd(input logic mode);
    logic [N-1:0] r;
    for (int l = 0; l < LANES; l++) begin
      if (mode)
        r[l*W +: W] = 24'($urandom_range(0, DQ - 1));
      else
        r[l*W +: W] = {12'($urandom_range(0, KQ - 1)),
                       12'($urandom_range(0, KQ - 1))};
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [N-1:0] got,
                     input logic [N-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called just after a falling edge: record handshakes, then run one cycle.
  task automatic tick();
    exp_t e;
    #1;
    last_acc = in_valid && in_ready;
    if (last_acc) q.push_back(model(kd_mode, in_a, in_b, halve));
    if (out_valid && out_ready) begin
      chk("result_expected", N'(q.size() != 0), N'(1));
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("sum", out_sum, e.s);
        chk("diff", out_diff, e.d);
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain();
    int n;
    n = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while ((q.size() != 0 || out_valid) && n < 20) begin
      tick();
      n++;
    end
    chk("drain_done", N'(q.size()), N'(0));
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; kd_mode = 1'b0;
    in_a = '0; in_b = '0; halve = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_out_valid", N'(out_valid), N'(0));
    chk("rst_out_sum", out_sum, '0);
    chk("rst_out_diff", out_diff, '0);
    chk("rst_in_ready", N'(in_ready), N'(1));

    // Kyber directed, latency
    kd_mode = 1'b0;
    in_a = {12'd100, 12'd200, 12'd3000, 12'd5};
    in_b = {12'd300, 12'd50, 12'd1000, 12'd10};
    in_valid = 1'b1;
    tick();
    chk("k_accept", N'(last_acc), N'(1));
    in_valid = 1'b0;
    #1 chk("k_lat1_valid", N'(out_valid), N'(0));
    tick();
    #1 chk("k_lat2_valid", N'(out_valid), N'(1));
    chk("k_sum0", N'(out_sum[23:0]), N'({12'd671, 12'd15}));
    chk("k_diff0", N'(out_diff[23:0]), N'({12'd2000, 12'd3324}));
    tick();

    // Dilithium directed
    kd_mode = 1'b1;
    in_a = {24'd0, 24'd8380416};
    in_b = {24'd1, 24'd1};
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    #1;
    chk("d_sum0", N'(out_sum[23:0]), N'(0));
    chk("d_diff0", N'(out_diff[23:0]), N'(8380415));
    chk("d_sum1", N'(out_sum[47:24]), N'(1));
    chk("d_diff1", N'(out_diff[47:24]), N'(8380416));
    tick();

    // Boundary: a+b=q, a=b
    kd_mode = 1'b0;
    in_a = {12'd1, 12'd7, 12'd3328, 12'd1664};
    in_b = {12'd3328, 12'd7, 12'd1, 12'd1665};
    in_valid = 1'b1;
    tick();
    drain();

    // Alternating mode, back-to-back
    for (int i = 0; i < 8; i++) begin
      kd_mode = i[0];
      in_a = rnd(kd_mode);
      in_b = rnd(kd_mode);
      in_valid = 1'b1;
      tick();
      chk("alt_no_bubble", N'(last_acc), N'(1));
    end
    drain();

    // Backpressure
    for (int i = 0; i < 4; i++) begin
      pm[i] = 1'($urandom_range(0, 1));
      pa[i] = rnd(pm[i]);
      pb[i] = rnd(pm[i]);
    end
    idx = 0;
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1;
      kd_mode = pm[idx]; in_a = pa[idx]; in_b = pb[idx];
      tick();
      if (last_acc) idx++;
      if (c == 1) begin snap_s = out_sum; snap_d = out_diff; end
    end
    #1;
    chk("stall_accepted", N'(idx), N'(2));
    chk("stall_in_ready", N'(in_ready), N'(0));
    chk("stall_valid", N'(out_valid), N'(1));
    chk("stall_sum_hold", out_sum, snap_s);
    chk("stall_diff_hold", out_diff, snap_d);
    out_ready = 1'b1;
    for (int c = 0; c < 30 && (idx < 4 || q.size() != 0); c++) begin
      in_valid = (idx < 4);
      if (idx < 4) begin
        kd_mode = pm[idx]; in_a = pa[idx]; in_b = pb[idx];
      end
      tick();
      if (last_acc) idx++;
    end
    chk("stall_all_in", N'(idx), N'(4));
    drain();

    // Reset with beats in flight
    kd_mode = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_a = rnd(1'b0);
      in_b = rnd(1'b0);
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    q.delete();
    #1;
    chk("mid_rst_valid", N'(out_valid), N'(0));
    chk("mid_rst_sum", out_sum, '0);
    chk("mid_rst_diff", out_diff, '0);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("no_stale", N'(out_valid), N'(0));
    end

`ifdef MOD_ADDSUB_HALVE_EN
    halve = 1'b1;
    kd_mode = 1'b0;
    in_a = {12'd3000, 12'd3000, 12'd3000, 12'd3000};
    in_b = {12'd1000, 12'd1000, 12'd1000, 12'd1000};
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    #1;
    chk("h_k_sum", N'(out_sum[11:0]), N'(2000));
    chk("h_k_diff", N'(out_diff[11:0]), N'(1000));
    tick();
    kd_mode = 1'b1;
    in_a = {24'd2, 24'd2};
    in_b = {24'd0, 24'd0};
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    #1;
    chk("h_d_sum", N'(out_sum[23:0]), N'(1));
    chk("h_d_diff", N'(out_diff[23:0]), N'(1));
    tick();
    halve = 1'b0;
`endif

    // Random traffic with random backpressure
    for (int c = 0; c < 300; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      kd_mode   = 1'($urandom_range(0, 1));
`ifdef MOD_ADDSUB_HALVE_EN
      halve     = 1'($urandom_range(0, 1));
`endif
      in_a = rnd(kd_mode);
      in_b = rnd(kd_mode);
      tick();
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
